jtag_shift_master: RTL



---
 rtl/jtag_shift_master.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_shift_master.sv
// JTAG master: converts TAP_RESET / SHIFT_IR / SHIFT_DR / IDLE commands into
// TCK/TMS/TDI/TRST waveforms and returns the captured TDO bits as one response.
module jtag_shift_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_tdi_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_tdo_o,
  output logic               rsp_err_o,
  output logic               jtag_tck_o,
  output logic               jtag_tms_o,
  output logic               jtag_tdi_o,
  output logic               jtag_trst_no,
  input  logic               jtag_tdo_i
);
  localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV - 1);
  localparam logic [7:0]      MAX_LEN_U8 = 8'(MAX_LEN);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_e;

  // Number of TCKs before the first shift bit (TAP starts in Run-Test/Idle).
  function automatic logic [7:0] pre_len(input logic [1:0] op);
    case (op)
      OP_IR:   return 8'd4;
      OP_DR:   return 8'd3;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] total_of(input logic [1:0] op, input logic [6:0] len);
    case (op)
      OP_RESET: return 8'd6;
      OP_IR:    return {1'b0, len} + 8'd6;
      OP_DR:    return {1'b0, len} + 8'd5;
      default:  return {1'b0, len};
    endcase
  endfunction

  function automatic logic in_shift(input logic [1:0] op, input logic [6:0] len,
                                    input logic [7:0] step);
    return ((op == OP_IR) || (op == OP_DR)) && (step >= pre_len(op)) &&
           (step < (pre_len(op) + {1'b0, len}));
  endfunction

  // Last shift bit and the following TCK carry TMS=1 (Exit1 -> Update), then 0 (-> Idle).
  function automatic logic tms_of(input logic [1:0] op, input logic [6:0] len,
                                  input logic [7:0] step);
    logic [7:0] last;
    last = pre_len(op) + {1'b0, len} - 8'd1;
    case (op)
      OP_RESET: return step < 8'd5;
      OP_IR:    return (step < 8'd4) ? (step < 8'd2) : ((step == last) || (step == last + 8'd1));
      OP_DR:    return (step < 8'd3) ? (step == 8'd0) : ((step == last) || (step == last + 8'd1));
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic trst_of(input logic [1:0] op, input logic [7:0] step);
    return !((op == OP_RESET) && (step < 8'd5));
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [6:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_in_q, data_in_d;
  logic [MAX_LEN-1:0] data_out_q, data_out_d;
  logic [7:0]         step_q, step_d;
  logic [7:0]         total_q, total_d;
  logic [DIVW-1:0]    div_q, div_d;
  logic               phase_q, phase_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_n_q, trst_n_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;

  logic [7:0]         step_nx;
  logic [IDXW-1:0]    idx_cur, idx_nx;
  logic               cmd_bad;
  logic [7:0]         cmd_total;
  logic               cmd_ready;

  assign cmd_ready    = (state_q == ST_IDLE) && !rsp_valid_q;
  assign cmd_ready_o  = cmd_ready;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_tdo_o    = data_out_q;
  assign rsp_err_o    = rsp_err_q;
  assign jtag_tck_o   = tck_q;
  assign jtag_tms_o   = tms_q;
  assign jtag_tdi_o   = tdi_q;
  assign jtag_trst_no = trst_n_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    data_in_d   = data_in_q;
    data_out_d  = data_out_q;
    step_d      = step_q;
    total_d     = total_q;
    div_d       = div_q;
    phase_d     = phase_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_n_d    = trst_n_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;

    step_nx   = step_q + 8'd1;
    idx_cur   = IDXW'(step_q - pre_len(op_q));
    idx_nx    = IDXW'(step_nx - pre_len(op_q));
    cmd_bad   = ((cmd_op_i == OP_IR) || (cmd_op_i == OP_DR)) &&
                ((cmd_len_i == 7'd0) || ({1'b0, cmd_len_i} > MAX_LEN_U8));
    cmd_total = total_of(cmd_op_i, cmd_len_i);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready) begin
          op_d       = cmd_op_i;
          len_d      = cmd_len_i;
          data_in_d  = cmd_tdi_i;
          data_out_d = '0;
          rsp_err_d  = 1'b0;
          step_d     = 8'd0;
          total_d    = cmd_total;
          div_d      = '0;
          phase_d    = 1'b0;
          if (cmd_bad) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else if (cmd_total == 8'd0) begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            // This edge opens the first low phase, so drive step 0 now.
            tms_d    = tms_of(cmd_op_i, cmd_len_i, 8'd0);
            tdi_d    = 1'b0;
            trst_n_d = trst_of(cmd_op_i, 8'd0);
            state_d  = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            tck_d   = 1'b1;
            if (in_shift(op_q, len_q, step_q)) data_out_d[idx_cur] = jtag_tdo_i;
          end else begin
            phase_d = 1'b0;
            tck_d   = 1'b0;
            if (step_q == total_q - 8'd1) begin
              tdi_d       = 1'b0;
              trst_n_d    = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = ST_RESP;
            end else begin
              step_d   = step_nx;
              tms_d    = tms_of(op_q, len_q, step_nx);
              tdi_d    = in_shift(op_q, len_q, step_nx) ? data_in_q[idx_nx] : 1'b0;
              trst_n_d = trst_of(op_q, step_nx);
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      len_q       <= 7'd0;
      data_in_q   <= '0;
      data_out_q  <= '0;
      step_q      <= 8'd0;
      total_q     <= 8'd0;
      div_q       <= '0;
      phase_q     <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_in_q   <= data_in_d;
      data_out_q  <= data_out_d;
      step_q      <= step_d;
      total_q     <= total_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_n_q    <= trst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule
